// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter
//   Multi-source interrupt controller between peripheral requesters and the CPU.
//   Samples masked level requests, picks one winner, raises INTR to the CPU,
//   acknowledges the winner for one cycle once the CPU enters the handler (ENTR),
//   and keeps it in service until software writes EOI.
//
//   Ports
//     clk        clock, all state on posedge
//     rst        synchronous reset, active low
//     reg_write  register write strobe (one cycle per write)
//     reg_addr   word select: 0 MASK, 1 PENDING, 2 EOI, 3 STATUS
//     reg_wdata  write data
//     reg_rdata  combinational read data for reg_addr
//     src_intr   level interrupt requests, one bit per source
//     src_ack    one-hot, one-cycle acknowledge to the granted source
//     INTR       interrupt request to the CPU (high in REQ)
//     ENTR       CPU handler entry, sampled only in REQ
//     irq_id     index of the granted source
//
//   Build option
//     INTR_ARB_ROUND_ROBIN_EN  round-robin arbitration; rr_ptr shown in STATUS[19:16].
//                              Undefined: fixed priority, lowest index wins.
module interrupt_arbiter #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int N_SRC              = 4,
  parameter int ID_W               = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reg_write,
  input  logic [1:0]                    reg_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] reg_wdata,
  output logic [C_M_AXI_DATA_WIDTH-1:0] reg_rdata,
  input  logic [N_SRC-1:0]              src_intr,
  output logic [N_SRC-1:0]              src_ack,
  output logic                          INTR,
  input  logic                          ENTR,
  output logic [ID_W-1:0]               irq_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [N_SRC-1:0]  r_mask;
  logic [N_SRC-1:0]  r_pending;
  logic [ID_W-1:0]   r_irq_id, w_irq_id_nxt;
  logic [N_SRC-1:0]  r_src_ack, w_src_ack_nxt;
  logic [ID_W-1:0]   w_winner;
  logic              w_mask_we, w_eoi, w_grant;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_rdata;
  logic              w_unused_wdata;

  assign w_mask_we = reg_write && (reg_addr == 2'd0);
  assign w_eoi     = reg_write && (reg_addr == 2'd2);
  // only the low N_SRC bits of a MASK write are kept; EOI data is ignored
  assign w_unused_wdata = &{1'b0, reg_wdata};

`ifdef INTR_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_rr_ptr;

  // Walk from the highest offset down so the smallest offset from rr_ptr
  // (with wrap) is the last assignment and wins.
  always_comb begin
    int v_idx;
    w_winner = '0;
    v_idx    = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= N_SRC) v_idx = v_idx - N_SRC;
      if (r_pending[ID_W'(v_idx)]) w_winner = ID_W'(v_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)         r_rr_ptr <= '0;
    else if (w_grant) r_rr_ptr <= (r_irq_id == ID_W'(N_SRC - 1)) ? '0 : r_irq_id + 1'b1;
  end
`else
  always_comb begin
    w_winner = '0;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (r_pending[ID_W'(k)]) w_winner = ID_W'(k);
  end
`endif

  // next-state / ack decode
  always_comb begin
    w_state_nxt   = r_state;
    w_irq_id_nxt  = r_irq_id;
    w_src_ack_nxt = '0;
    w_grant       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_irq_id_nxt = w_winner;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        // ENTR beats a same-cycle withdrawal: the CPU is already committed
        if (ENTR) begin
          w_grant       = 1'b1;
          w_src_ack_nxt = N_SRC'(1) << r_irq_id;
          w_state_nxt   = ST_SERVICE;
        end else if (!r_pending[r_irq_id]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (w_eoi) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_mask    <= '0;
      r_pending <= '0;
      r_irq_id  <= '0;
      r_src_ack <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_id  <= w_irq_id_nxt;
      r_src_ack <= w_src_ack_nxt;
      // pending uses the mask as it was before any same-cycle write
      r_pending <= src_intr & r_mask;
      if (w_mask_we) r_mask <= reg_wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (reg_addr)
      2'd0: w_rdata[N_SRC-1:0] = r_mask;
      2'd1: w_rdata[N_SRC-1:0] = r_pending;
      2'd3: begin
        w_rdata[9:8]      = r_state;
        w_rdata[ID_W-1:0] = r_irq_id;
`ifdef INTR_ARB_ROUND_ROBIN_EN
        w_rdata[16 +: ID_W] = r_rr_ptr;
`endif
      end
      default: w_rdata = '0;
    endcase
  end

  assign reg_rdata = w_rdata;
  assign src_ack   = r_src_ack;
  assign INTR      = (r_state == ST_REQ);
  assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed table-driven bench for interrupt_arbiter (N_SRC=4), plus a
// hand-written arbitration sequence whose expectations follow the build option.
module tb_interrupt_arbiter;

`ifdef INTR_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic [3:0]  src_intr = '0;
  logic [3:0]  src_ack;
  logic        INTR;
  logic        ENTR = 1'b0;
  logic [1:0]  irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  interrupt_arbiter #(.C_M_AXI_DATA_WIDTH(32), .N_SRC(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .src_intr(src_intr),
    .src_ack(src_ack), .INTR(INTR), .ENTR(ENTR), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [3:0]  intr;
    logic        entr;
    logic        e_intr;
    logic [3:0]  e_ack;
    logic        chk_id;
    logic [1:0]  e_id;
    logic [31:0] e_rd;
  } row_t;

  row_t vec[$];

  function automatic row_t mk(logic r, logic we, logic [1:0] a, logic [31:0] wd,
                              logic [3:0] in, logic en, logic ei, logic [3:0] ea,
                              logic ci, logic [1:0] eid, logic [31:0] erd);
    row_t x;
    x.rst = r; x.we = we; x.addr = a; x.wd = wd; x.intr = in; x.entr = en;
    x.e_intr = ei; x.e_ack = ea; x.chk_id = ci; x.e_id = eid; x.e_rd = erd;
    return x;
  endfunction

  task automatic check(string nm, int idx, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, got, exp);
    end
  endtask

  // inputs applied at negedge, outputs sampled 1ns after the following posedge
  task automatic run_row(row_t x, int idx);
    @(negedge clk);
    rst = x.rst; reg_write = x.we; reg_addr = x.addr; reg_wdata = x.wd;
    src_intr = x.intr; ENTR = x.entr;
    @(posedge clk);
    #1;
    check("INTR",    idx, 32'(INTR),    32'(x.e_intr));
    check("src_ack", idx, 32'(src_ack), 32'(x.e_ack));
    if (x.chk_id) check("irq_id", idx, 32'(irq_id), 32'(x.e_id));
    check("rdata",   idx, reg_rdata,    x.e_rd);
  endtask

  initial begin
    //               rst we a  wdata         intr en | INTR ack chkid id rdata
    // reset with all requests high
    vec.push_back(mk(0, 0, 0, 32'h0,        4'hF, 0,  0, 4'h0, 1, 0, 32'h0));
    vec.push_back(mk(0, 0, 3, 32'h0,        4'hF, 0,  0, 4'h0, 1, 0, 32'h0));
    // mask 0: nothing pending, EOI in IDLE is a no-op and reads 0
    vec.push_back(mk(1, 0, 1, 32'h0,        4'hF, 0,  0, 4'h0, 1, 0, 32'h0));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'hF, 0,  0, 4'h0, 1, 0, 32'h0));
    vec.push_back(mk(1, 1, 2, 32'hFFFFFFFF, 4'hF, 0,  0, 4'h0, 1, 0, 32'h0));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'hF, 0,  0, 4'h0, 1, 0, 32'h0));
    // basic: mask=1, src0 rises, REQ two cycles later, ENTR -> ack, EOI
    vec.push_back(mk(1, 1, 0, 32'h1,        4'h0, 0,  0, 4'h0, 0, 0, 32'h1));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h1, 0,  0, 4'h0, 0, 0, 32'h1));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h1, 0,  1, 4'h0, 1, 0, 32'h100));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h1, 1,  0, 4'h1, 1, 0, RR ? 32'h10200 : 32'h200));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h1, 0,  0, 4'h0, 1, 0, RR ? 32'h10200 : 32'h200));
    vec.push_back(mk(1, 1, 2, 32'h0,        4'h0, 0,  0, 4'h0, 1, 0, 32'h0));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h0, 0,  0, 4'h0, 0, 0, RR ? 32'h10000 : 32'h0));
    // withdrawal: src2 requests then drops, no ack
    vec.push_back(mk(1, 1, 0, 32'h4,        4'h4, 0,  0, 4'h0, 0, 0, 32'h4));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  0, 4'h0, 0, 0, 32'h4));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  1, 4'h0, 1, 2, 32'h4));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h0, 0,  1, 4'h0, 1, 2, 32'h0));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h0, 0,  0, 4'h0, 0, 0, RR ? 32'h10002 : 32'h2));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h0, 0,  0, 4'h0, 0, 0, RR ? 32'h10002 : 32'h2));
    // withdrawal coinciding with ENTR: ENTR wins
    vec.push_back(mk(1, 0, 0, 32'h0,        4'h4, 0,  0, 4'h0, 0, 0, 32'h4));
    vec.push_back(mk(1, 0, 0, 32'h0,        4'h4, 0,  1, 4'h0, 1, 2, 32'h4));
    vec.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0,  1, 4'h0, 1, 2, 32'h4));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h0, 1,  0, 4'h4, 1, 2, RR ? 32'h30202 : 32'h202));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h0, 0,  0, 4'h0, 1, 2, RR ? 32'h30202 : 32'h202));
    vec.push_back(mk(1, 1, 2, 32'h0,        4'h0, 0,  0, 4'h0, 0, 0, 32'h0));
    // masking the requester while in REQ drops INTR two cycles after the write
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  0, 4'h0, 0, 0, 32'h4));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  1, 4'h0, 1, 2, 32'h4));
    vec.push_back(mk(1, 1, 0, 32'h0,        4'h4, 0,  1, 4'h0, 1, 2, 32'h0));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  1, 4'h0, 1, 2, 32'h0));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  0, 4'h0, 0, 0, 32'h0));
    // reset while in SERVICE
    vec.push_back(mk(1, 1, 0, 32'h4,        4'h4, 0,  0, 4'h0, 0, 0, 32'h4));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  0, 4'h0, 0, 0, 32'h4));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  1, 4'h0, 1, 2, 32'h4));
    vec.push_back(mk(1, 0, 3, 32'h0,        4'h4, 1,  0, 4'h4, 1, 2, RR ? 32'h30202 : 32'h202));
    vec.push_back(mk(0, 0, 3, 32'h0,        4'h4, 0,  0, 4'h0, 1, 0, 32'h0));
    vec.push_back(mk(1, 0, 0, 32'h0,        4'h4, 0,  0, 4'h0, 1, 0, 32'h0));
    vec.push_back(mk(1, 0, 1, 32'h0,        4'h4, 0,  0, 4'h0, 1, 0, 32'h0));

    for (int i = 0; i < vec.size(); i++) run_row(vec[i], i);

    // arbitration among sources 1 and 3 held high across two services
    run_row(mk(1, 1, 0, 32'hF, 4'hA, 0,  0, 4'h0, 0, 0, 32'hF), 100);
    run_row(mk(1, 0, 1, 32'h0, 4'hA, 0,  0, 4'h0, 0, 0, 32'hA), 101);
    run_row(mk(1, 0, 3, 32'h0, 4'hA, 0,  1, 4'h0, 1, 1, 32'h101), 102);
    run_row(mk(1, 0, 1, 32'h0, 4'hA, 1,  0, 4'h2, 1, 1, 32'hA), 103);
    run_row(mk(1, 1, 2, 32'h0, 4'hA, 0,  0, 4'h0, 1, 1, 32'h0), 104);
    run_row(mk(1, 0, 1, 32'h0, 4'hA, 0,  1, 4'h0, 1, RR ? 2'd3 : 2'd1, 32'hA), 105);
    run_row(mk(1, 0, 3, 32'h0, 4'hA, 1,  0, RR ? 4'h8 : 4'h2, 1, RR ? 2'd3 : 2'd1,
               RR ? 32'h203 : 32'h201), 106);
    run_row(mk(1, 1, 2, 32'h0, 4'hA, 0,  0, 4'h0, 0, 0, 32'h0), 107);
    run_row(mk(1, 0, 3, 32'h0, 4'hA, 0,  1, 4'h0, 1, 1, 32'h101), 108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
